// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default operand/digit widths and the
// sequential-subtractor state encoding.
package alu_pkg;

    localparam int unsigned NDefault    = 32;
    localparam int unsigned WDefault    = 8;
    localparam int unsigned CntWDefault = $clog2(NDefault / WDefault);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sub_state_e;

endpackage

// File: rtl/sub_slice.sv
// W-bit combinational subtract slice: diff = a - b - bin, with the borrow out of the top bit.
module sub_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         bin_i,
    output logic [W-1:0] diff_o,
    output logic         bout_o
);

    logic [W:0] wide;

    // The extra top bit of the (W+1)-bit difference is the borrow.
    always_comb begin
        wide   = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, bin_i};
        diff_o = wide[W-1:0];
        bout_o = wide[W];
    end

endmodule

// File: rtl/sub_32_seq.sv
// Digit-serial N-bit subtractor with borrow-in/out: W bits per cycle through sub_slice,
// start/busy/done handshake, results held in output registers until the next completion.
module sub_32_seq
    import alu_pkg::*;
#(
    parameter int unsigned N = NDefault,
    parameter int unsigned W = WDefault
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] res,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned Digits = N / W;
    localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Digits - 1);

    sub_state_e    state_q;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]  a_q, b_q, shadow_q;
    logic          a_sign_q, b_sign_q;
    logic          borrow_q;
    logic          busy_q, done_q, bout_q, ovf_q, zero_q;
    logic [N-1:0]  res_q;

    logic [W-1:0]  slice_diff;
    logic          slice_bout;
    logic [N-1:0]  res_d;
    logic          ovf_d;

    // Operands shift right each step so the current digit is always the low W bits.
    sub_slice #(
        .W(W)
    ) u_slice (
        .a_i   (a_q[W-1:0]),
        .b_i   (b_q[W-1:0]),
        .bin_i (borrow_q),
        .diff_o(slice_diff),
        .bout_o(slice_bout)
    );

    always_comb begin
        res_d = {slice_diff, shadow_q[N-1:W]};
        ovf_d = (a_sign_q != b_sign_q) && (res_d[N-1] != a_sign_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q  <= StRun;
                        cnt_q    <= '0;
                        a_q      <= a;
                        b_q      <= b;
                        a_sign_q <= a[N-1];
                        b_sign_q <= b[N-1];
                        borrow_q <= bin;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q      <= a_q >> W;
                    b_q      <= b_q >> W;
                    shadow_q <= res_d;
                    borrow_q <= slice_bout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        res_q   <= res_d;
                        bout_q  <= slice_bout;
                        ovf_q   <= ovf_d;
                        zero_q  <= (res_d == '0);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_sub_32_seq.sv
// Scoreboard bench for sub_32_seq: driver pushes expected results on accept, monitor checks on done.
module tb_sub_32_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, ovf, zero;
    logic [31:0] res;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic        bout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    sub_32_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .res  (res),
        .bout (bout),
        .ovf  (ovf),
        .zero (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 33-bit arithmetic on the whole operands.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mbin, input int acc_cyc);
        exp_t e;
        logic [32:0] need;
        e.res  = ma - mb - {31'd0, mbin};
        need   = {1'b0, mb} + {32'd0, mbin};
        e.bout = ({1'b0, ma} < need);
        e.ovf  = (ma[31] != mb[31]) && (e.res[31] != ma[31]);
        e.zero = (e.res == 32'd0);
        e.cyc  = acc_cyc + 4;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res", res, e.res);
                chk("bout", {31'd0, bout}, {31'd0, e.bout});
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                chk("zero", {31'd0, zero}, {31'd0, e.zero});
                chk("latency", cyc, e.cyc);
            end
        end
    end

    // Drive start in the current cycle, push expectation at the accepting edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ibin);
        start = 1'b1;
        a = ia;
        b = ib;
        bin = ibin;
        @(posedge clk);
        #1;
        sb.push_back(model(ia, ib, ibin, cyc));
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        bin = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic op(input logic [31:0] ia, input logic [31:0] ib, input logic ibin);
        @(negedge clk);
        issue(ia, ib, ibin);
        wait_done();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", res, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);

        op(32'hAAAAAAAA, 32'h55555555, 1'b0);
        op(32'hAAAAAAAA, 32'h55555555, 1'b1);
        op(32'h3, 32'h2, 1'b1);
        op(32'h0, 32'h1, 1'b0);
        op(32'h0, 32'hFFFFFFFF, 1'b1);
        op(32'h12345678, 32'h12345678, 1'b1);

        // Reset mid-run: outstanding expectation is cancelled, outputs cleared.
        @(negedge clk);
        issue(32'd10, 32'd1, 1'b0);
        @(negedge clk);
        chk("busy_run", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_res", res, 32'd0);
        repeat (8) @(negedge clk);

        // Start during RUN is ignored.
        @(negedge clk);
        issue(32'h00000100, 32'h00000001, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a = 32'hDEADBEEF;
        b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);

        // Back-to-back: new start presented during the DONE cycle.
        @(negedge clk);
        issue(32'h00000005, 32'h00000007, 1'b0);
        wait_done();
        issue(32'h80000000, 32'h00000001, 1'b0);
        wait_done();

        for (int i = 0; i < 25; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 5 == 0) ? ra : $urandom;
            op(ra, rb, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
